// File: rtl/alu_pkg.sv
// Shared ALU definitions: default datapath width, sequencer state encoding and
// slice-count helper used by the multi-cycle arithmetic blocks.
package alu_pkg;

  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int unsigned slice_count(input int unsigned data_w,
                                              input int unsigned slice_w);
    return data_w / slice_w;
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/slice_subtractor.sv
// W-bit ripple slice computing a + nb + cin, where nb is the already-inverted
// subtrahend slice; chain depth is W full-adder stages.
module slice_subtractor #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] nb_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  logic [W:0] c;

  assign c[0] = cin_i;

  for (genvar i = 0; i < W; i++) begin : g_bit
    full_adder u_fa (
      .a_i    (a_i[i]),
      .b_i    (nb_i[i]),
      .cin_i  (c[i]),
      .sum_o  (sum_o[i]),
      .cout_o (c[i+1])
    );
  end

  assign cout_o = c[W];

endmodule

// File: rtl/serial_subtractor_32_bit.sv
// Multi-cycle two's-complement subtractor: one SLICE_W-bit slice of a - b per
// clock with a carry register between slices; results/flags held until next op.
module serial_subtractor_32_bit
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned SLICE_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] diff,
  output logic              borrow,
  output logic              overflow,
  output logic              zero,
  output logic              negative
);

  localparam int unsigned N   = slice_count(DATA_W, SLICE_W);
  localparam int unsigned KW  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned MSB = DATA_W - 1;

  if ((DATA_W % SLICE_W) != 0) begin : g_width_check
    $error("DATA_W must be a multiple of SLICE_W");
  end

  state_e            state_q;
  logic [KW-1:0]     k_q;
  logic              carry_q;
  logic [DATA_W-1:0] op_a_q;
  logic [DATA_W-1:0] op_nb_q;
  logic [DATA_W-1:0] res_q;
  logic [DATA_W-1:0] diff_q;
  logic              borrow_q;
  logic              overflow_q;
  logic              zero_q;
  logic              negative_q;

  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_nb;
  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout;
  logic [DATA_W-1:0]  res_d;
  logic               overflow_d;
  logic               last_slice;

  always_comb begin
    slice_a  = op_a_q[k_q*SLICE_W +: SLICE_W];
    slice_nb = op_nb_q[k_q*SLICE_W +: SLICE_W];
  end

  slice_subtractor #(
    .W (SLICE_W)
  ) u_slice (
    .a_i    (slice_a),
    .nb_i   (slice_nb),
    .cin_i  (carry_q),
    .sum_o  (slice_sum),
    .cout_o (slice_cout)
  );

  // res_d merges the slice being produced this cycle, so the final edge can
  // load the complete difference straight into the output registers.
  always_comb begin
    res_d = res_q;
    res_d[k_q*SLICE_W +: SLICE_W] = slice_sum;
    overflow_d = (op_a_q[MSB] == op_nb_q[MSB]) & (res_d[MSB] != op_a_q[MSB]);
    last_slice = (k_q == KW'(N - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      k_q        <= '0;
      carry_q    <= 1'b0;
      op_a_q     <= '0;
      op_nb_q    <= '0;
      res_q      <= '0;
      diff_q     <= '0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            op_a_q  <= a;
            op_nb_q <= ~b;
            carry_q <= 1'b1;
            k_q     <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          res_q   <= res_d;
          carry_q <= slice_cout;
          if (last_slice) begin
            k_q        <= '0;
            state_q    <= DONE;
            diff_q     <= res_d;
            borrow_q   <= ~slice_cout;
            overflow_q <= overflow_d;
            zero_q     <= (res_d == '0);
            negative_q <= res_d[MSB];
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready    = (state_q == IDLE);
  assign done     = (state_q == DONE);
  assign diff     = diff_q;
  assign borrow   = borrow_q;
  assign overflow = overflow_q;
  assign zero     = zero_q;
  assign negative = negative_q;

endmodule

// File: tb/tb_serial_subtractor_32_bit.sv
// Directed bench for serial_subtractor_32_bit with a scoreboard of expected
// results pushed at start and popped on each done pulse.
module tb_serial_subtractor_32_bit;

  localparam int unsigned N = 8;

  typedef struct packed {
    logic [31:0] diff;
    logic        borrow;
    logic        overflow;
    logic        zero;
    logic        negative;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        ready, done, borrow, overflow, zero, negative;
  logic [31:0] diff;

  int tests = 0;
  int fails = 0;
  exp_t sb[$];

  serial_subtractor_32_bit #(
    .DATA_W  (32),
    .SLICE_W (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .ready    (ready),
    .done     (done),
    .diff     (diff),
    .borrow   (borrow),
    .overflow (overflow),
    .zero     (zero),
    .negative (negative)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    e.diff     = x - y;
    e.borrow   = (x < y);
    e.overflow = (x[31] != y[31]) && (e.diff[31] != x[31]);
    e.zero     = (e.diff == 32'd0);
    e.negative = e.diff[31];
    return e;
  endfunction

  task automatic check_cleared(input string tag);
    chk({tag, ".ready"}, 32'(ready), 32'd1);
    chk({tag, ".done"}, 32'(done), 32'd0);
    chk({tag, ".diff"}, diff, 32'd0);
    chk({tag, ".flags"}, {28'd0, borrow, overflow, zero, negative}, 32'd0);
  endtask

  task automatic check_result(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, ".diff"}, diff, e.diff);
      chk({tag, ".borrow"}, 32'(borrow), 32'(e.borrow));
      chk({tag, ".overflow"}, 32'(overflow), 32'(e.overflow));
      chk({tag, ".zero"}, 32'(zero), 32'(e.zero));
      chk({tag, ".negative"}, 32'(negative), 32'(e.negative));
    end
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 40) begin
      step();
      cyc++;
    end
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (!ready && guard < 40) begin
      step();
      guard++;
    end
    chk("wait_ready", 32'(ready), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y);
    int cyc;
    wait_ready();
    a = x;
    b = y;
    start = 1'b1;
    sb.push_back(model(x, y));
    step();
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    chk({tag, ".busy"}, 32'(ready), 32'd0);
    wait_done(cyc);
    chk({tag, ".latency"}, 32'(cyc), 32'(N));
    check_result(tag);
    step();
    chk({tag, ".done_single"}, 32'(done), 32'd0);
    chk({tag, ".ready_back"}, 32'(ready), 32'd1);
  endtask

  initial begin
    int cyc;
    int ndone;

    step();
    step();
    rst = 1'b0;
    check_cleared("reset");

    run_op("sub_100_58", 32'd100, 32'd58);
    run_op("sub_0_1", 32'd0, 32'd1);
    run_op("ovf_min_1", 32'h8000_0000, 32'd1);
    run_op("ovf_max_m1", 32'h7FFF_FFFF, 32'hFFFF_FFFF);

    // start held high: two operations back to back, 10 cycles apart
    a = 32'h1234_5678;
    b = 32'h1234_5678;
    start = 1'b1;
    sb.push_back(model(a, b));
    sb.push_back(model(a, b));
    step();
    wait_done(cyc);
    chk("hold.latency1", 32'(cyc), 32'(N));
    check_result("hold.op1");
    step();
    chk("hold.done_single1", 32'(done), 32'd0);
    wait_done(cyc);
    chk("hold.interval", 32'(cyc + 1), 32'(N + 2));
    start = 1'b0;
    check_result("hold.op2");
    step();
    chk("hold.done_single2", 32'(done), 32'd0);

    // start pulsed during RUN must be ignored
    wait_ready();
    a = 32'd10;
    b = 32'd4;
    start = 1'b1;
    sb.push_back(model(32'd10, 32'd4));
    step();
    start = 1'b0;
    step();
    step();
    step();
    a = 32'd7;
    b = 32'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(cyc);
    chk("ignore.latency", 32'(cyc + 4), 32'(N));
    check_result("ignore.op");
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (done) ndone++;
    end
    chk("ignore.no_second_done", 32'(ndone), 32'd0);
    chk("ignore.sb_drained", 32'(sb.size()), 32'd0);

    // reset in RUN aborts; start on the same edge as rst is not accepted
    a = 32'd50;
    b = 32'd20;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    step();
    rst = 1'b1;
    start = 1'b1;
    step();
    rst = 1'b0;
    start = 1'b0;
    check_cleared("abort");
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done) ndone++;
    end
    chk("abort.no_done", 32'(ndone), 32'd0);
    chk("abort.idle", 32'(ready), 32'd1);

    run_op("after_abort", 32'd9, 32'd2);
    run_op("rand", 32'hDEAD_BEEF, 32'h0BAD_F00D);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
